bird_motion: RTL and testbench
==============================

BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 Parameters SHALL be, one per line:
- START_HEIGHT, 240: height loaded on reset and on return to IDLE.
- GRAVITY, 1: velocity increment per tick.
- FLAP_VEL, 8: upward speed magnitude applied on a flap.
- MAX_FALL, 10: downward velocity cap.
- MAX_HEIGHT, 479: lower screen bound for the height clamp.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  synchronous active-low reset.
- tick  input  1  one-cycle frame-update pulse.
- flap  input  1  flap button level, already synchronised.
- start  input  1  start/restart button level, already synchronised.
- is_dead  input  1  collision flag from the dead-zone checker, which flags height<10 or height>420.
- height  output  9  bird top y-coordinate; increases downward; registered.
- velocity  output  7  signed two's-complement y-velocity; positive means falling; registered.
- state  output  2  00 IDLE, 01 PLAYING, 10 DEAD; 11 is unused.
REQ-003 The design SHALL use one clock, clk, and a synchronous active-low reset, rst_n.

Function
REQ-004 flap and start SHALL each be rising-edge detected against a one-cycle registered copy.
REQ-005 A flap edge in PLAYING SHALL set flap_pending.
REQ-006 flap_pending SHALL clear on the tick that consumes it, and SHALL be held at 0 in IDLE and DEAD.
REQ-007 IDLE: height=START_HEIGHT and velocity=0; a start edge SHALL move to PLAYING on the next cycle; tick SHALL be ignored.
REQ-008 PLAYING, tick=1, is_dead=0: vel_new SHALL be -FLAP_VEL if flap_pending (or a flap edge in the same cycle), else min(velocity+GRAVITY, MAX_FALL).
REQ-009 On that tick, height SHALL become clamp(height+vel_new, 0, MAX_HEIGHT), computed in 10-bit signed arithmetic; velocity SHALL become vel_new. Both SHALL be visible the cycle after the tick.
REQ-010 PLAYING, tick=0: height and velocity SHALL hold.
REQ-011 PLAYING, is_dead=1: next state SHALL be DEAD; is_dead SHALL override a simultaneous tick, with no height or velocity update.
REQ-012 DEAD: height and velocity SHALL freeze; tick and flap SHALL be ignored.
REQ-013 DEAD: a start edge SHALL move to IDLE and reload START_HEIGHT and velocity 0 on the same edge.
REQ-014 A start edge in PLAYING SHALL be ignored.
REQ-015 The height clamp SHALL prevent 9-bit wrap at both bounds.
REQ-016 The velocity cap SHALL be applied before the height add.
REQ-017 Encoding 11 SHALL recover to IDLE on the next clock.

Reset
REQ-018 While rst_n=0 at a clk edge: state=IDLE, height=START_HEIGHT, velocity=0, flap_pending=0, and both edge-detect registers=0.
REQ-019 Reset asserted mid-PLAYING SHALL abandon the game with no further tick processing.

Structure
REQ-020 A shared package SHALL hold the state encoding constants, the screen bounds (MAX_HEIGHT 479, dead limits 10/420) and the physics defaults, so the dead-zone checker and bird_motion agree.
REQ-021 One sub-module, edge_detect (level in, one-cycle pulse out, clk/rst_n), SHALL be instantiated twice, for flap and start.
REQ-022 All other logic SHALL be flat: the FSM plus the physics datapath.

Verification
REQ-023 Reset, then start edge, then 3 ticks with no flap -> velocity 1,2,3; height 241,243,246; state 01.
REQ-024 From height 246, velocity 3: flap pulse, then tick -> velocity -8 (7'h78), height 238; a second tick with no flap -> velocity -7, height 231.
REQ-025 Height 5, flap, then tick -> height clamps to 0 with no wrap. Falling with 15 ticks -> velocity saturates at 10.
REQ-026 is_dead=1 together with tick in PLAYING at height 421 -> state 10, height stays 421; further ticks and flaps change nothing; a start edge -> state 00, height 240, velocity 0.
REQ-027 rst_n=0 for one cycle mid-PLAYING (height 300, velocity 5) -> next cycle state 00, height 240, velocity 0; a flap held across reset produces no edge.
REQ-028 Flap edge and tick in the same cycle -> flap applied on that tick (velocity -8); flap in IDLE -> no effect after start.

Source files
------------

// File: rtl/bird_motion_pkg.sv
// Shared constants for the bird game: state encoding, screen bounds and
// physics defaults, so bird_motion and the dead-zone checker agree.
package bird_motion_pkg;

  // FSM encoding, also the value driven on the state output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAYING = 2'b01,
    ST_DEAD    = 2'b10,
    ST_RSVD    = 2'b11
  } state_e;

  // Datapath widths.
  localparam int HEIGHT_W = 9;
  localparam int VEL_W    = 7;
  localparam int CALC_W   = 10;

  // Screen bounds. Height grows downward; MAX_HEIGHT is the bottom row.
  localparam int MAX_HEIGHT_DEF = 479;
  localparam int DEAD_LO        = 10;
  localparam int DEAD_HI        = 420;

  // Physics defaults.
  localparam int START_HEIGHT_DEF = 240;
  localparam int GRAVITY_DEF      = 1;
  localparam int FLAP_VEL_DEF     = 8;
  localparam int MAX_FALL_DEF     = 10;

  // Clamp a signed candidate height into [0, hi] so the 9-bit register
  // never wraps past either screen edge.
  function automatic logic [HEIGHT_W-1:0] clamp_height(
    input logic signed [CALC_W-1:0] value,
    input logic signed [CALC_W-1:0] hi
  );
    logic [HEIGHT_W-1:0] result;
    if (value[CALC_W-1]) begin
      result = '0;
    end else if (value > hi) begin
      result = hi[HEIGHT_W-1:0];
    end else begin
      result = value[HEIGHT_W-1:0];
    end
    return result;
  endfunction

  // Dead-zone rule used by the collision checker.
  function automatic logic in_dead_zone(input logic [HEIGHT_W-1:0] h);
    return (h < HEIGHT_W'(DEAD_LO)) || (h > HEIGHT_W'(DEAD_HI));
  endfunction

endpackage

// File: rtl/bird_motion_edge_detect.sv
// Rising-edge detector: one-cycle pulse when the level goes 0 -> 1,
// judged against a one-cycle registered copy of the level.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  // Registered copy of the level; cleared by reset so a level held across
  // reset is seen as fresh, which the FSM ignores because reset lands in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/bird_motion.sv
// Bird vertical motion: IDLE/PLAYING/DEAD FSM plus a per-tick physics
// datapath (gravity, flap impulse, fall cap, screen clamp).
//
// Handshake note: there is no valid/ready pair here. tick is a one-cycle
// strobe; every update it causes is visible on height/velocity the cycle
// after the strobe. flap/start are levels turned into one-cycle pulses.
module bird_motion
  import bird_motion_pkg::*;
#(
  parameter int START_HEIGHT = START_HEIGHT_DEF,
  parameter int GRAVITY      = GRAVITY_DEF,
  parameter int FLAP_VEL     = FLAP_VEL_DEF,
  parameter int MAX_FALL     = MAX_FALL_DEF,
  parameter int MAX_HEIGHT   = MAX_HEIGHT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     flap,
  input  logic                     start,
  input  logic                     is_dead,
  output logic [HEIGHT_W-1:0]      height,
  output logic signed [VEL_W-1:0]  velocity,
  output logic [1:0]               state
);

  localparam logic [HEIGHT_W-1:0]      START_H  = HEIGHT_W'(START_HEIGHT);
  localparam logic signed [CALC_W-1:0] GRAV_S   = CALC_W'(GRAVITY);
  localparam logic signed [CALC_W-1:0] FLAPV_S  = CALC_W'(FLAP_VEL);
  localparam logic signed [CALC_W-1:0] NEG_FLAP = -FLAPV_S;
  localparam logic signed [CALC_W-1:0] FALL_S   = CALC_W'(MAX_FALL);
  localparam logic signed [CALC_W-1:0] MAXH_S   = CALC_W'(MAX_HEIGHT);

  state_e                    state_q, state_d;
  logic [HEIGHT_W-1:0]       height_q, height_d;
  logic signed [VEL_W-1:0]   vel_q, vel_d;
  logic                      flap_pending_q, flap_pending_d;

  logic flap_edge;
  logic start_edge;

  logic signed [CALC_W-1:0] vel_ext;
  logic signed [CALC_W-1:0] vel_inc;
  logic signed [CALC_W-1:0] vel_cap;
  logic signed [CALC_W-1:0] vel_new;
  logic signed [CALC_W-1:0] h_ext;
  logic signed [CALC_W-1:0] h_sum;
  logic                     flap_now;

  edge_detect u_flap_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (flap),
    .pulse_o (flap_edge)
  );

  edge_detect u_start_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (start),
    .pulse_o (start_edge)
  );

  // Physics for one tick: the fall cap is applied to the velocity first,
  // then the capped velocity is added to the height and clamped to screen.
  always_comb begin
    flap_now = flap_pending_q | flap_edge;
    vel_ext  = {{(CALC_W-VEL_W){vel_q[VEL_W-1]}}, vel_q};
    vel_inc  = vel_ext + GRAV_S;
    vel_cap  = (vel_inc > FALL_S) ? FALL_S : vel_inc;
    vel_new  = flap_now ? NEG_FLAP : vel_cap;
    h_ext    = {1'b0, height_q};
    h_sum    = h_ext + vel_new;
  end

  // Next-state and datapath update; every target holds unless a case moves it.
  always_comb begin
    state_d        = state_q;
    height_d       = height_q;
    vel_d          = vel_q;
    flap_pending_d = flap_pending_q;
    unique case (state_q)
      ST_IDLE: begin
        height_d       = START_H;
        vel_d          = '0;
        flap_pending_d = 1'b0;
        if (start_edge) begin
          state_d = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (is_dead) begin
          // Collision wins over a simultaneous tick: freeze as-is.
          state_d        = ST_DEAD;
          flap_pending_d = 1'b0;
        end else if (tick) begin
          vel_d          = vel_new[VEL_W-1:0];
          height_d       = clamp_height(h_sum, MAXH_S);
          flap_pending_d = 1'b0;
        end else if (flap_edge) begin
          flap_pending_d = 1'b1;
        end
      end
      ST_DEAD: begin
        flap_pending_d = 1'b0;
        if (start_edge) begin
          state_d  = ST_IDLE;
          height_d = START_H;
          vel_d    = '0;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        height_d       = START_H;
        vel_d          = '0;
        flap_pending_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      height_q       <= START_H;
      vel_q          <= '0;
      flap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      height_q       <= height_d;
      vel_q          <= vel_d;
      flap_pending_q <= flap_pending_d;
    end
  end

  assign height   = height_q;
  assign velocity = vel_q;
  assign state    = state_q;

endmodule

// File: tb/tb_bird_motion.sv
// Directed self-checking bench for bird_motion.
module tb_bird_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       flap = 1'b0;
  logic       start = 1'b0;
  logic       is_dead = 1'b0;
  logic [8:0] height;
  logic [6:0] velocity;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  bird_motion dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .flap     (flap),
    .start    (start),
    .is_dead  (is_dead),
    .height   (height),
    .velocity (velocity),
    .state    (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Drivers: inputs change 1 ns after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick(input logic with_flap);
    tick = 1'b1;
    flap = with_flap;
    step();
    tick = 1'b0;
    flap = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic pulse_flap();
    flap = 1'b1;
    step();
    flap = 1'b0;
    step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %h want 00", state); end
    n_tests++; if (height !== 9'd240) begin n_fail++; $display("FAIL reset_height got %0d want 240", height); end
    n_tests++; if (velocity !== 7'h00) begin n_fail++; $display("FAIL reset_velocity got %h want 00", velocity); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_ignores();
    pulse_tick(1'b0);
    pulse_flap();
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL idle_state got %h want 00", state); end
    n_tests++; if (height !== 9'd240) begin n_fail++; $display("FAIL idle_height got %0d want 240", height); end
    n_tests++; if (velocity !== 7'h00) begin n_fail++; $display("FAIL idle_velocity got %h want 00", velocity); end
  endtask

  task automatic test_fall();
    int ev[3] = '{1, 2, 3};
    int eh[3] = '{241, 243, 246};
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++; if (state !== 2'b01) begin n_fail++; $display("FAIL start_state got %h want 01", state); end
    step();
    for (int i = 0; i < 3; i++) begin
      pulse_tick(1'b0);
      n_tests++; if (velocity !== 7'(ev[i])) begin n_fail++; $display("FAIL fall_velocity[%0d] got %h want %h", i, velocity, 7'(ev[i])); end
      n_tests++; if (height !== 9'(eh[i])) begin n_fail++; $display("FAIL fall_height[%0d] got %0d want %0d", i, height, eh[i]); end
    end
    // No tick: hold.
    step(); step(); step();
    n_tests++; if (height !== 9'd246) begin n_fail++; $display("FAIL hold_height got %0d want 246", height); end
    n_tests++; if (velocity !== 7'h03) begin n_fail++; $display("FAIL hold_velocity got %h want 03", velocity); end
    // Start edge while playing is ignored.
    pulse_start();
    n_tests++; if (state !== 2'b01) begin n_fail++; $display("FAIL start_in_play_state got %h want 01", state); end
    n_tests++; if (height !== 9'd246) begin n_fail++; $display("FAIL start_in_play_height got %0d want 246", height); end
  endtask

  task automatic test_flap();
    pulse_flap();
    n_tests++; if (velocity !== 7'h03) begin n_fail++; $display("FAIL flap_pending_no_tick got %h want 03", velocity); end
    pulse_tick(1'b0);
    n_tests++; if (velocity !== 7'h78) begin n_fail++; $display("FAIL flap_velocity got %h want 78", velocity); end
    n_tests++; if (height !== 9'd238) begin n_fail++; $display("FAIL flap_height got %0d want 238", height); end
    pulse_tick(1'b0);
    n_tests++; if (velocity !== 7'h79) begin n_fail++; $display("FAIL after_flap_velocity got %h want 79", velocity); end
    n_tests++; if (height !== 9'd231) begin n_fail++; $display("FAIL after_flap_height got %0d want 231", height); end
  endtask

  task automatic test_same_cycle_flap();
    pulse_tick(1'b1);
    n_tests++; if (velocity !== 7'h78) begin n_fail++; $display("FAIL same_cycle_velocity got %h want 78", velocity); end
    n_tests++; if (height !== 9'd223) begin n_fail++; $display("FAIL same_cycle_height got %0d want 223", height); end
    pulse_tick(1'b0);
    n_tests++; if (velocity !== 7'h79) begin n_fail++; $display("FAIL pending_cleared_velocity got %h want 79", velocity); end
    n_tests++; if (height !== 9'd216) begin n_fail++; $display("FAIL pending_cleared_height got %0d want 216", height); end
  endtask

  task automatic test_clamp_and_cap();
    apply_reset();
    pulse_flap();             // flap in IDLE must not carry into the game
    pulse_start();
    pulse_tick(1'b0);
    n_tests++; if (velocity !== 7'h01) begin n_fail++; $display("FAIL idle_flap_velocity got %h want 01", velocity); end
    n_tests++; if (height !== 9'd241) begin n_fail++; $display("FAIL idle_flap_height got %0d want 241", height); end
    for (int i = 0; i < 30; i++) pulse_tick(1'b1);
    n_tests++; if (height !== 9'd1) begin n_fail++; $display("FAIL climb_height got %0d want 1", height); end
    pulse_tick(1'b1);         // 1 - 8 = -7 must clamp to 0, not wrap to 505
    n_tests++; if (height !== 9'd0) begin n_fail++; $display("FAIL top_clamp_height got %0d want 0", height); end
    n_tests++; if (velocity !== 7'h78) begin n_fail++; $display("FAIL top_clamp_velocity got %h want 78", velocity); end
    for (int i = 0; i < 7; i++) pulse_tick(1'b0);
    n_tests++; if (height !== 9'd0) begin n_fail++; $display("FAIL top_hold_height got %0d want 0", height); end
    n_tests++; if (velocity !== 7'h7f) begin n_fail++; $display("FAIL top_hold_velocity got %h want 7f", velocity); end
    for (int i = 0; i < 13; i++) pulse_tick(1'b0);
    n_tests++; if (velocity !== 7'd10) begin n_fail++; $display("FAIL fall_cap_velocity got %0d want 10", velocity); end
    n_tests++; if (height !== 9'd75) begin n_fail++; $display("FAIL fall_cap_height got %0d want 75", height); end
    for (int i = 0; i < 40; i++) pulse_tick(1'b0);
    n_tests++; if (height !== 9'd475) begin n_fail++; $display("FAIL near_bottom_height got %0d want 475", height); end
    pulse_tick(1'b0);
    n_tests++; if (height !== 9'd479) begin n_fail++; $display("FAIL bottom_clamp_height got %0d want 479", height); end
    pulse_tick(1'b0);
    n_tests++; if (height !== 9'd479) begin n_fail++; $display("FAIL bottom_hold_height got %0d want 479", height); end
    n_tests++; if (velocity !== 7'd10) begin n_fail++; $display("FAIL bottom_velocity got %0d want 10", velocity); end
  endtask

  task automatic test_dead();
    is_dead = 1'b1;
    tick    = 1'b1;
    step();
    is_dead = 1'b0;
    tick    = 1'b0;
    step();
    n_tests++; if (state !== 2'b10) begin n_fail++; $display("FAIL dead_state got %h want 10", state); end
    n_tests++; if (height !== 9'd479) begin n_fail++; $display("FAIL dead_height got %0d want 479", height); end
    n_tests++; if (velocity !== 7'd10) begin n_fail++; $display("FAIL dead_velocity got %0d want 10", velocity); end
    pulse_tick(1'b1);
    pulse_flap();
    pulse_tick(1'b0);
    n_tests++; if (state !== 2'b10) begin n_fail++; $display("FAIL dead_frozen_state got %h want 10", state); end
    n_tests++; if (height !== 9'd479) begin n_fail++; $display("FAIL dead_frozen_height got %0d want 479", height); end
    n_tests++; if (velocity !== 7'd10) begin n_fail++; $display("FAIL dead_frozen_velocity got %0d want 10", velocity); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL restart_state got %h want 00", state); end
    n_tests++; if (height !== 9'd240) begin n_fail++; $display("FAIL restart_height got %0d want 240", height); end
    n_tests++; if (velocity !== 7'h00) begin n_fail++; $display("FAIL restart_velocity got %h want 00", velocity); end
    step();
    pulse_start();
    pulse_tick(1'b0);
    n_tests++; if (velocity !== 7'h01) begin n_fail++; $display("FAIL replay_velocity got %h want 01", velocity); end
    n_tests++; if (height !== 9'd241) begin n_fail++; $display("FAIL replay_height got %0d want 241", height); end
  endtask

  task automatic test_reset_mid_play();
    for (int i = 0; i < 4; i++) pulse_tick(1'b0);
    n_tests++; if (height !== 9'd255) begin n_fail++; $display("FAIL pre_reset_height got %0d want 255", height); end
    n_tests++; if (velocity !== 7'h05) begin n_fail++; $display("FAIL pre_reset_velocity got %h want 05", velocity); end
    flap  = 1'b1;
    tick  = 1'b1;
    rst_n = 1'b0;
    step();
    tick  = 1'b0;
    rst_n = 1'b1;
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL mid_reset_state got %h want 00", state); end
    n_tests++; if (height !== 9'd240) begin n_fail++; $display("FAIL mid_reset_height got %0d want 240", height); end
    n_tests++; if (velocity !== 7'h00) begin n_fail++; $display("FAIL mid_reset_velocity got %h want 00", velocity); end
    step();
    // flap still held high through start: no edge reaches the game.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_tests++; if (state !== 2'b01) begin n_fail++; $display("FAIL post_reset_start_state got %h want 01", state); end
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    n_tests++; if (velocity !== 7'h01) begin n_fail++; $display("FAIL held_flap_velocity got %h want 01", velocity); end
    n_tests++; if (height !== 9'd241) begin n_fail++; $display("FAIL held_flap_height got %0d want 241", height); end
    flap = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_idle_ignores();
    test_fall();
    test_flap();
    test_same_cycle_flap();
    test_clamp_and_cap();
    test_dead();
    test_reset_mid_play();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
